// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared constants, class encodings and FSM states for the perceptron sequencer
package perceptron_pkg;
    localparam int N_IN = 25;
    localparam logic [1:0] CLS_CROSS = 2'b10;
    localparam logic [1:0] CLS_CIRCLE = 2'b01;
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_GAP, S_EPOCH_END, S_FINISH
    } state_t;
    function automatic logic [1:0] label_cls(input logic label);
        return label ? CLS_CROSS : CLS_CIRCLE;
    endfunction
endpackage

// File: rtl/perceptron_seq_if.sv
// perceptron_seq_if: sequencer-to-perceptron link (pixel vector, enable, ready, class)
interface perceptron_seq_if;
    import perceptron_pkg::*;
    logic [N_IN-1:0] p_in;
    logic p_en;
    logic p_ready;
    logic [1:0] p_out;
    modport master (output p_in, p_en, input p_ready, p_out);
    modport slave (input p_in, p_en, output p_ready, p_out);
endinterface

// File: rtl/perceptron_seq_sample_buf.sv
// sample_buf: labelled sample store, one synchronous write port and one asynchronous read port
module sample_buf #(
    parameter int DEPTH = 8,
    parameter int W = 26
) (
    input  logic clk,
    input  logic we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [W-1:0] wd,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [W-1:0] rd
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    assign rd = mem[ra];
endmodule

// File: rtl/perceptron_seq.sv
// perceptron_seq: presents stored labelled samples to a perceptron over epochs and scores its answers
module perceptron_seq
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SETTLE = 6,
    parameter int TIMEOUT = 127,
    parameter int MAX_EPOCH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1,
    localparam int EW = $clog2(MAX_EPOCH) + 1,
    localparam int HW = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N_IN-1:0] wr_data,
    input  logic wr_label,
    input  logic [CW-1:0] n_samples,
    input  logic start,
    output logic busy,
    output logic done,
    output logic timeout_err,
    output logic [EW-1:0] epoch_cnt,
    output logic [CW-1:0] err_cnt,
    perceptron_seq_if.master pif,
    output logic res_valid,
    output logic [AW-1:0] res_idx,
    output logic res_match
);
    state_t state, nxt;
    logic [AW-1:0] idx, rd_addr;
    logic [CW-1:0] n_lat, run_err;
    logic [HW-1:0] hold;
    logic [N_IN:0] rd_data, smp;
    logic en, match, we, n_ok, accept, expire, last, stop, load;

    assign we = wr_en && !busy;
    // the only loads come from IDLE/EPOCH_END (entry 0) or GAP (next entry)
    assign rd_addr = state == S_GAP ? idx + 1'b1 : '0;

    sample_buf #(.DEPTH(DEPTH), .W(N_IN + 1)) u_buf (
        .clk(clk),
        .we(we),
        .wa(wr_addr),
        .wd({wr_label, wr_data}),
        .ra(rd_addr),
        .rd(rd_data)
    );

    assign n_ok = n_samples != '0 && n_samples <= CW'(DEPTH);
    assign accept = state == S_WAIT && pif.p_ready && hold >= HW'(SETTLE);
    assign expire = state == S_WAIT && !accept && hold == HW'(TIMEOUT - 1);
    assign last = {1'b0, idx} == n_lat - 1'b1;
    assign stop = run_err == '0 || epoch_cnt + 1'b1 == EW'(MAX_EPOCH);
    assign load = nxt == S_ISSUE;
    assign pif.p_en = en;
    assign pif.p_in = smp[N_IN-1:0];
    assign res_idx = idx;
    assign res_match = res_valid && match;

    always_ff @(posedge clk)
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        busy = state != S_IDLE && state != S_FINISH;
        done = state == S_FINISH;
        res_valid = state == S_CAPTURE;
        case (state)
            S_IDLE:      nxt = start ? (n_ok ? S_ISSUE : S_FINISH) : S_IDLE;
            S_ISSUE:     nxt = S_WAIT;
            S_WAIT:      nxt = accept ? S_CAPTURE : expire ? S_FINISH : S_WAIT;
            S_CAPTURE:   nxt = S_GAP;
            S_GAP:       nxt = last ? S_EPOCH_END : S_ISSUE;
            S_EPOCH_END: nxt = stop ? S_FINISH : S_ISSUE;
            default:     nxt = S_IDLE;
        endcase
    end

    // hold counts cycles p_en has already been high, so WAIT lasts at least SETTLE cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en <= 1'b0;
            smp <= '0;
            idx <= '0;
            n_lat <= '0;
            hold <= '0;
            run_err <= '0;
            match <= 1'b0;
            err_cnt <= '0;
            epoch_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                timeout_err <= 1'b0;
                if (n_ok) begin
                    n_lat <= n_samples;
                    epoch_cnt <= '0;
                    run_err <= '0;
                end
            end
            if (load) begin
                en <= 1'b1;
                hold <= HW'(1);
                idx <= rd_addr;
                smp <= (we && wr_addr == rd_addr) ? {wr_label, wr_data} : rd_data;
            end
            if (state == S_WAIT) hold <= &hold ? hold : hold + 1'b1;
            if (accept) match <= pif.p_out == label_cls(smp[N_IN]);
            if (state == S_CAPTURE) begin
                en <= 1'b0;
                run_err <= run_err + CW'(!match);
            end
            if (expire) begin
                en <= 1'b0;
                timeout_err <= 1'b1;
            end
            if (state == S_EPOCH_END) begin
                err_cnt <= run_err;
                epoch_cnt <= epoch_cnt + 1'b1;
                if (!stop) run_err <= '0;
            end
        end
    end
endmodule

// File: tb/tb_perceptron_seq.sv
// tb_perceptron_seq: randomized bench with a behavioural perceptron model and epoch-level reference
module tb_perceptron_seq;
    import perceptron_pkg::*;
    localparam int DEPTH = 8, SETTLE = 6, TIMEOUT = 127, MAX_EPOCH = 16;
    localparam int AW = 3, CW = 4, EW = 5;

    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, wr_label = 1'b0, start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N_IN-1:0] wr_data = '0;
    logic [CW-1:0] n_samples = '0;
    logic busy, done, timeout_err, res_valid, res_match;
    logic [EW-1:0] epoch_cnt;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] res_idx;

    perceptron_seq_if pif();

    perceptron_seq #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .MAX_EPOCH(MAX_EPOCH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_label(wr_label), .n_samples(n_samples), .start(start), .busy(busy), .done(done),
        .timeout_err(timeout_err), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt), .pif(pif),
        .res_valid(res_valid), .res_idx(res_idx), .res_match(res_match)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    logic [N_IN-1:0] ref_mem [DEPTH];
    logic ref_lbl [DEPTH];
    int rdy_d = 0, out_mode = 0, hang_at = 1000;
    int cyc = 0, en_cnt = 0, low_cnt = 0, done_n = 0, done_cyc = 0, issue_cyc = 0;
    logic done_pen = 1'b0;
    logic [1:0] cur_out = 2'b00;
    logic [N_IN-1:0] pin_q [$];
    logic [1:0] pout_q [$];
    int gap_q [$], ridx_q [$], rlat_q [$];
    logic rmatch_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] lookup(input logic [N_IN-1:0] d);
        for (int i = 0; i < DEPTH; i++)
            if (ref_mem[i] == d) return label_cls(ref_lbl[i]);
        return 2'b00;
    endfunction

    // perceptron model: picks its answer when p_en rises, raises ready after rdy_d enabled cycles
    always @(negedge clk) begin
        logic [1:0] c;
        if (pif.p_en === 1'b1) begin
            if (en_cnt == 0) begin
                c = lookup(pif.p_in);
                cur_out = out_mode == 0 ? c : out_mode == 1 ? CLS_CROSS :
                          ($urandom_range(3) != 0 ? c : 2'($urandom_range(3)));
                pin_q.push_back(pif.p_in);
                pout_q.push_back(cur_out);
                gap_q.push_back(low_cnt);
                issue_cyc = cyc;
            end
            en_cnt++;
            low_cnt = 0;
        end else begin
            en_cnt = 0;
            low_cnt++;
        end
        pif.p_ready = pif.p_en === 1'b1 && en_cnt >= rdy_d + 1 && pin_q.size() <= hang_at;
        pif.p_out = cur_out;
        if (res_valid === 1'b1) begin
            ridx_q.push_back(int'(res_idx));
            rmatch_q.push_back(res_match);
            rlat_q.push_back(en_cnt);
        end
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
            done_pen = pif.p_en;
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic clear_logs();
        pin_q.delete(); pout_q.delete(); gap_q.delete();
        ridx_q.delete(); rmatch_q.delete(); rlat_q.delete();
        done_n = 0;
    endtask

    task automatic write(input int a, input logic [N_IN-1:0] d, input logic l);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_label = l;
        ref_mem[a] = d; ref_lbl[a] = l;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        n_samples = CW'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_n == 0 && k < budget) begin tick(); k++; end
        compared++;
        if (done_n == 0) begin
            mismatched++;
            $display("FAIL %s_done: no done within %0d cycles", name, budget);
        end
        tick(2);
    endtask

    // reference: replay epochs from the answers the model gave and the stored labels
    task automatic check_run(input string name, input int n);
        int k = 0, e = 0, errs = 0, lat;
        logic m;
        lat = 2 + (rdy_d > SETTLE ? rdy_d : SETTLE);
        do begin
            errs = 0;
            for (int i = 0; i < n; i++) begin
                if (k >= ridx_q.size() || k >= pin_q.size()) begin
                    compared++; mismatched++;
                    $display("FAIL %s_count: got %0d results, required more than %0d", name, ridx_q.size(), k);
                    return;
                end
                m = pout_q[k] == label_cls(ref_lbl[i]);
                compared++;
                if (pin_q[k] !== ref_mem[i]) begin mismatched++; $display("FAIL %s_p_in[%0d]: got %h required %h", name, k, pin_q[k], ref_mem[i]); end
                compared++;
                if (ridx_q[k] != i) begin mismatched++; $display("FAIL %s_res_idx[%0d]: got %0d required %0d", name, k, ridx_q[k], i); end
                compared++;
                if (rmatch_q[k] !== m) begin mismatched++; $display("FAIL %s_res_match[%0d]: got %b required %b", name, k, rmatch_q[k], m); end
                compared++;
                if (rlat_q[k] != lat) begin mismatched++; $display("FAIL %s_latency[%0d]: got %0d required %0d", name, k, rlat_q[k], lat); end
                if (i > 0) begin
                    compared++;
                    if (gap_q[k] != 1) begin mismatched++; $display("FAIL %s_gap[%0d]: got %0d required 1", name, k, gap_q[k]); end
                end
                errs += m ? 0 : 1;
                k++;
            end
            e++;
        end while (errs != 0 && e < MAX_EPOCH);
        compared++;
        if (ridx_q.size() != k) begin mismatched++; $display("FAIL %s_count: got %0d results required %0d", name, ridx_q.size(), k); end
        compared++;
        if (epoch_cnt !== EW'(e)) begin mismatched++; $display("FAIL %s_epoch_cnt: got %0d required %0d", name, epoch_cnt, e); end
        compared++;
        if (err_cnt !== CW'(errs)) begin mismatched++; $display("FAIL %s_err_cnt: got %0d required %0d", name, err_cnt, errs); end
        compared++;
        if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL %s_timeout_err: got %b required 0", name, timeout_err); end
        compared++;
        if (done_n != 1 || busy !== 1'b0) begin mismatched++; $display("FAIL %s_end: done pulses %0d busy %b required 1 and 0", name, done_n, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        compared++;
        if ({busy, done, timeout_err, res_valid, pif.p_en} !== 5'b0) begin
            mismatched++; $display("FAIL reset_flags: got %b required 00000", {busy, done, timeout_err, res_valid, pif.p_en});
        end
        compared++;
        if (epoch_cnt !== '0 || err_cnt !== '0) begin
            mismatched++; $display("FAIL reset_counters: got epoch %0d err %0d required 0 0", epoch_cnt, err_cnt);
        end
        compared++;
        if (pif.p_in !== '0) begin mismatched++; $display("FAIL reset_p_in: got %h required 0", pif.p_in); end
    endtask

    task automatic init_mem();
        logic [N_IN-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = N_IN'($urandom);
            d[2:0] = 3'(i);
            write(i, d, 1'($urandom));
        end
    endtask

    task automatic test_correct();
        write(0, 25'h0454544, 1'b0);
        write(1, 25'h0151151, 1'b1);
        out_mode = 0; rdy_d = 0;
        clear_logs();
        pulse_start(2);
        wait_done("correct", 200);
        check_run("correct", 2);
        compared++;
        if (epoch_cnt !== 5'd1 || err_cnt !== 4'd0) begin
            mismatched++; $display("FAIL correct_totals: got epoch %0d err %0d required 1 0", epoch_cnt, err_cnt);
        end
    endtask

    task automatic test_always_cross();
        out_mode = 1; rdy_d = $urandom_range(9);
        clear_logs();
        pulse_start(2);
        wait_done("cross", 5000);
        check_run("cross", 2);
        compared++;
        if (epoch_cnt !== 5'd16 || err_cnt !== 4'd1) begin
            mismatched++; $display("FAIL cross_totals: got epoch %0d err %0d required 16 1", epoch_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        out_mode = 0; rdy_d = 0; hang_at = 1;
        clear_logs();
        pulse_start(3);
        while (pin_q.size() < 2 && k < 100) begin tick(); k++; end
        tick(3);
        rst_n = 1'b0;
        tick();
        compared++;
        if ({busy, done, pif.p_en, timeout_err, res_valid} !== 5'b0) begin
            mismatched++; $display("FAIL midreset_flags: got %b required 00000", {busy, done, pif.p_en, timeout_err, res_valid});
        end
        compared++;
        if (epoch_cnt !== '0 || err_cnt !== '0) begin
            mismatched++; $display("FAIL midreset_counters: got epoch %0d err %0d required 0 0", epoch_cnt, err_cnt);
        end
        rst_n = 1'b1;
        tick(5);
        compared++;
        if (done_n != 0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL midreset_done: got %0d done pulses busy %b required 0 0", done_n, busy);
        end
        hang_at = 1000;
    endtask

    task automatic test_timeout();
        rdy_d = 1000;
        clear_logs();
        pulse_start(2);
        wait_done("timeout", 400);
        compared++;
        if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL timeout_flag: got %b required 1", timeout_err); end
        compared++;
        if (done_cyc - issue_cyc != TIMEOUT) begin
            mismatched++; $display("FAIL timeout_delay: got %0d required %0d", done_cyc - issue_cyc, TIMEOUT);
        end
        compared++;
        if (done_pen !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL timeout_p_en: got p_en %b busy %b required 0 0", done_pen, busy); end
        compared++;
        if (pin_q.size() != 1 || ridx_q.size() != 0) begin
            mismatched++; $display("FAIL timeout_samples: got %0d issued %0d results required 1 0", pin_q.size(), ridx_q.size());
        end
    endtask

    task automatic test_settle();
        out_mode = 0; rdy_d = 2;
        clear_logs();
        pulse_start(2);
        wait_done("settle", 300);
        check_run("settle", 2);
    endtask

    task automatic test_bad_n();
        int bad [2];
        bad[0] = 0;
        bad[1] = $urandom_range(9, 15);
        for (int j = 0; j < 2; j++) begin
            pulse_start(bad[j]);
            compared++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                mismatched++; $display("FAIL bad_n%0d_pulse: got done %b busy %b required 1 0", bad[j], done, busy);
            end
            tick();
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++; $display("FAIL bad_n%0d_after: got done %b busy %b required 0 0", bad[j], done, busy);
            end
        end
    endtask

    task automatic test_busy_ignore();
        out_mode = 2; rdy_d = 0;
        clear_logs();
        pulse_start(4);
        tick(15);
        n_samples = 4'd1; start = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = ~ref_mem[2]; wr_label = ~ref_lbl[2];
        tick();
        start = 1'b0; wr_en = 1'b0;
        tick(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_ignore", 4000);
        check_run("busy_ignore", 4);
    endtask

    task automatic test_wr_start();
        logic [N_IN-1:0] d;
        d = N_IN'($urandom);
        d[2:0] = 3'd0;
        out_mode = 0; rdy_d = $urandom_range(9);
        clear_logs();
        wr_en = 1'b1; wr_addr = '0; wr_data = d; wr_label = 1'($urandom);
        ref_mem[0] = d; ref_lbl[0] = wr_label;
        pulse_start(3);
        wr_en = 1'b0;
        wait_done("wr_start", 300);
        check_run("wr_start", 3);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            init_mem();
            n = $urandom_range(1, DEPTH);
            out_mode = 2; rdy_d = $urandom_range(9);
            clear_logs();
            pulse_start(n);
            wait_done("random", 4000);
            check_run("random", n);
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_correct();
        test_always_cross();
        test_reset_mid();
        test_timeout();
        test_settle();
        test_bad_n();
        test_busy_ignore();
        test_wr_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/perceptron_seq.md
Name: perceptron_seq

Overview:
Sequencer that owns the perceptron datapath and feeds it a stored sample set. It holds up to DEPTH labelled 25-pixel samples and presents them one by one on the perceptron's in/en interface. For each sample it waits for the ready/settle handshake, captures out, compares it with the label and counts mismatches. It repeats the set for multiple epochs until an error-free epoch occurs or the epoch limit is reached.

Parameters:
N_IN, 25, pixel vector width (5x5 image)
DEPTH, 8, sample buffer entries (power of 2)
SETTLE, 6, minimum cycles p_en is held before p_ready may be accepted
TIMEOUT, 127, max WAIT cycles before abort
MAX_EPOCH, 16, epoch limit

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write sample buffer entry (ignored while busy)
wr_addr  in  $clog2(DEPTH)  entry index
wr_data  in  N_IN  pixel vector
wr_label  in  1  1=cross, 0=circle
n_samples  in  $clog2(DEPTH)+1  samples per epoch, sampled at start
start  in  1  one-cycle run request
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
timeout_err  out  1  sticky, set on handshake timeout, cleared by start
epoch_cnt  out  $clog2(MAX_EPOCH)+1  epochs completed in current/last run
err_cnt  out  $clog2(DEPTH)+1  mismatches in last completed epoch
p_in  out  N_IN  to perceptron in
p_en  out  1  to perceptron en
p_ready  in  1  from perceptron ready
p_out  in  2  from perceptron out
res_valid  out  1  one-cycle pulse per classified sample
res_idx  out  $clog2(DEPTH)  sample index of result
res_match  out  1  p_out agreed with label

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. Buffer contents are not reset.
- Class encoding: p_out 2'b10 = cross, 2'b01 = circle. 2'b00 and 2'b11 always count as mismatch.
- FSM states and transitions:
  - IDLE: on start with n_samples in 1..DEPTH, latch n_samples, clear epoch_cnt/timeout_err, idx=0, go to ISSUE. start with n_samples=0 or >DEPTH gives a done pulse next cycle with busy never set.
  - ISSUE: drive p_in=buf[idx], p_en=1, hold=0, go to WAIT. p_in is registered and stable for the whole sample.
  - WAIT: p_en=1, hold++ saturating. When p_ready=1 and hold>=SETTLE, go to CAPTURE. When hold reaches TIMEOUT, set timeout_err, drop p_en and go to FINISH.
  - CAPTURE: register p_out, compare with label, pulse res_valid/res_idx/res_match, increment the running error count on mismatch, drop p_en. Go to GAP.
  - GAP: one cycle with p_en=0. If idx==n_samples-1, go to EPOCH_END; else idx++ and go to ISSUE.
  - EPOCH_END: err_cnt<=running count, epoch_cnt++. If running count==0 or epoch_cnt+1==MAX_EPOCH, go to FINISH; else clear running count, set idx=0 and go to ISSUE.
  - FINISH: pulse done, busy=0, go to IDLE.
- busy is high from the cycle after an accepted start until the FINISH cycle, exclusive.
- Minimum per-sample latency: ISSUE(1)+WAIT(SETTLE)+CAPTURE(1)+GAP(1).
- start while busy is ignored.
- wr_en while busy is ignored. wr_en and start in the same IDLE cycle: the write lands, and the run sees the new data.
- rst_n low mid-run: next edge gives IDLE, p_en=0, busy=0, no done pulse.
- p_ready high before SETTLE cycles elapse is ignored; it must still be high once the hold condition is met.

Decomposition:
- Package perceptron_pkg holds the FSM state enum, the class encodings CLS_CROSS=2'b10 and CLS_CIRCLE=2'b01, and N_IN.
- One sub-module, sample_buf: DEPTH x (N_IN+1) register file with one synchronous write port and one asynchronous read port.

Test Plan:
- Load entry0=25'h0454544/label0 and entry1=25'h0151151/label1, n_samples=2, model returns the correct class. Required: res_match=1 twice, done after 1 epoch, err_cnt=0, epoch_cnt=1.
- Same load, model always returns 2'b10. Required: err_cnt=1 every epoch, done after MAX_EPOCH=16 epochs, epoch_cnt=16.
- Model asserts p_ready at hold=2. Required: capture no earlier than hold=SETTLE=6, and p_en low for exactly 1 cycle between samples.
- Model never asserts p_ready. Required: timeout_err=1 and done pulse 127 cycles after ISSUE, with p_en=0.
- Assert rst_n=0 during WAIT of sample 1. Required: next cycle busy=0, p_en=0, all counters 0, no done pulse.
- start with n_samples=0. Required: done pulse, busy stays 0. start during a run has no effect on idx or epoch_cnt.
